// File: rtl/direction_input_ctrl.sv
// Button front end for the snake game: synchronise, debounce, edge-detect and
// turn presses into one pending direction that commits on the game-step tick.
module direction_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_n,
  input  logic       down_n,
  input  logic       left_n,
  input  logic       right_n,
  input  logic       tick,
  output logic [1:0] dir_out,
  output logic       turn,
  output logic [3:0] pressed,
  output logic       req_pending
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  logic [3:0] w_raw_n;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_lvl;
  logic [3:0] w_stable;
  logic [3:0] r_pressed;
  logic [3:0] r_pressed_d;
  logic [3:0] w_event;

  logic [1:0] w_cand;
  logic       w_cand_valid;
  logic       w_commit;
  logic [1:0] w_eff;
  logic       w_accept;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_dir;
  logic [1:0] w_dir_next;
  logic       r_turn;
  logic       w_turn_next;
  logic [1:0] r_req_dir;
  logic [1:0] w_req_dir_next;

  assign w_raw_n = {right_n, left_n, down_n, up_n};

  // Synchronisers hold the raw active-low value; released means all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= w_raw_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lvl = ~r_sync2;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_db
      logic [CNT_W-1:0] r_cnt;
      logic             r_stable;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (w_lvl[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_stable <= w_lvl[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_stable[gi] = r_stable;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pressed   <= 4'b0000;
      r_pressed_d <= 4'b0000;
    end else begin
      r_pressed   <= w_stable;
      r_pressed_d <= r_pressed;
    end
  end

  assign w_event = r_pressed & ~r_pressed_d;

  always_comb begin
    w_cand_valid = |w_event;
    w_cand       = 2'b11;
    if (w_event[0])      w_cand = 2'b00;
    else if (w_event[1]) w_cand = 2'b01;
    else if (w_event[2]) w_cand = 2'b10;
    else                 w_cand = 2'b11;
  end

  // Opposite directions differ only in bit 0 (up/down, left/right).
  assign w_commit = tick && (r_state == S_PENDING);
  assign w_eff    = w_commit ? r_req_dir : r_dir;
  assign w_accept = w_cand_valid && (w_cand != {w_eff[1], ~w_eff[0]});

  always_comb begin
    w_state_next   = r_state;
    w_dir_next     = r_dir;
    w_turn_next    = 1'b0;
    w_req_dir_next = r_req_dir;
    if (w_commit) begin
      w_dir_next  = r_req_dir;
      w_turn_next = (r_req_dir != r_dir);
    end
    if (w_accept) w_req_dir_next = w_cand;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = S_PENDING;
      S_PENDING: if (!w_accept && tick) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dir     <= 2'b11;
      r_turn    <= 1'b0;
      r_req_dir <= 2'b11;
    end else begin
      r_state   <= w_state_next;
      r_dir     <= w_dir_next;
      r_turn    <= w_turn_next;
      r_req_dir <= w_req_dir_next;
    end
  end

  assign dir_out     = r_dir;
  assign turn        = r_turn;
  assign pressed     = r_pressed;
  assign req_pending = (r_state == S_PENDING);

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Scoreboard bench for direction_input_ctrl with a short debounce window;
// expectations are queued against a target cycle and checked on the falling edge.
module tb_direction_input_ctrl;

  localparam int SEL_DIR  = 0;
  localparam int SEL_TURN = 1;
  localparam int SEL_PRS  = 2;
  localparam int SEL_PEND = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_n = 1'b1;
  logic       down_n = 1'b1;
  logic       left_n = 1'b1;
  logic       right_n = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] dir_out;
  logic       turn;
  logic [3:0] pressed;
  logic       req_pending;

  typedef struct {
    int    cyc;
    string tag;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb[$];
  exp_t sb_keep[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  direction_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .up_n       (up_n),
    .down_n     (down_n),
    .left_n     (left_n),
    .right_n    (right_n),
    .tick       (tick),
    .dir_out    (dir_out),
    .turn       (turn),
    .pressed    (pressed),
    .req_pending(req_pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end else begin
      $display("  ok %s = %0d (cycle %0d)", tag, got, cyc);
    end
  endtask

  function automatic int observe(input int sel);
    case (sel)
      SEL_DIR:  return int'(dir_out);
      SEL_TURN: return int'(turn);
      SEL_PRS:  return int'(pressed);
      default:  return int'(req_pending);
    endcase
  endfunction

  // Pop and compare every expectation that targets the current cycle.
  always @(negedge clk) begin
    sb_keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) check_val(sb[i].tag, observe(sb[i].sel), sb[i].val);
      else sb_keep.push_back(sb[i]);
    end
    sb = sb_keep;
  end

  task automatic expect_at(input int dly, input string tag, input int sel, input int val);
    exp_t e;
    e.cyc = cyc + dly;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_all(input int dly, input string tag, input int d, input int t,
                            input int p, input int q);
    expect_at(dly, {tag, "_dir"}, SEL_DIR, d);
    expect_at(dly, {tag, "_turn"}, SEL_TURN, t);
    expect_at(dly, {tag, "_pressed"}, SEL_PRS, p);
    expect_at(dly, {tag, "_pend"}, SEL_PEND, q);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a button mask down long enough to debounce, then release and settle.
  task automatic press(input logic [3:0] m);
    {right_n, left_n, down_n, up_n} = ~m;
    step(8);
    {right_n, left_n, down_n, up_n} = 4'hF;
    step(8);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    step(2);
    expect_all(0, "reset", 3, 0, 0, 0);
    reset = 1'b0;
    step(2);

    // Three-sample glitch must not debounce
    up_n = 1'b0;
    step(3);
    up_n = 1'b1;
    expect_at(3, "glitch_prs_a", SEL_PRS, 0);
    expect_at(6, "glitch_prs_b", SEL_PRS, 0);
    expect_at(7, "glitch_pend", SEL_PEND, 0);
    step(8);

    // Held press: pressed after 6 edges past first sample, request one later
    up_n = 1'b0;
    expect_at(6, "hold_prs_early", SEL_PRS, 0);
    expect_at(7, "hold_prs", SEL_PRS, 1);
    expect_at(7, "hold_pend_early", SEL_PEND, 0);
    expect_at(8, "hold_pend", SEL_PEND, 1);
    step(8);
    up_n = 1'b1;
    expect_at(6, "rel_prs_early", SEL_PRS, 1);
    expect_at(7, "rel_prs", SEL_PRS, 0);
    expect_at(8, "rel_pend", SEL_PEND, 1);
    step(8);

    // Commit up, then an idle tick
    expect_all(1, "commit_up", 0, 1, 0, 0);
    expect_at(2, "commit_turn_drop", SEL_TURN, 0);
    pulse_tick();
    step(1);
    expect_at(1, "idle_tick_turn", SEL_TURN, 0);
    expect_at(1, "idle_tick_dir", SEL_DIR, 0);
    pulse_tick();

    // Back to right
    expect_at(8, "right_pend", SEL_PEND, 1);
    press(4'b1000);
    expect_at(1, "right_dir", SEL_DIR, 3);
    expect_at(1, "right_turn", SEL_TURN, 1);
    pulse_tick();

    // Left from right is a reversal
    expect_at(7, "rev_prs", SEL_PRS, 4);
    expect_at(8, "rev_pend", SEL_PEND, 0);
    expect_at(16, "rev_pend_late", SEL_PEND, 0);
    press(4'b0100);
    expect_at(1, "rev_dir", SEL_DIR, 3);
    expect_at(1, "rev_turn", SEL_TURN, 0);
    pulse_tick();

    // Up and down together: up wins
    expect_at(7, "prio_prs", SEL_PRS, 3);
    expect_at(8, "prio_pend", SEL_PEND, 1);
    press(4'b0011);
    expect_at(1, "prio_dir", SEL_DIR, 0);
    expect_at(1, "prio_turn", SEL_TURN, 1);
    pulse_tick();

    // Overwrite: up then down pending, tick commits down
    press(4'b1000);
    expect_at(1, "ow_setup_dir", SEL_DIR, 3);
    pulse_tick();
    expect_at(8, "ow_up_pend", SEL_PEND, 1);
    press(4'b0001);
    expect_at(8, "ow_down_pend", SEL_PEND, 1);
    press(4'b0010);
    expect_all(1, "ow_commit", 1, 1, 0, 0);
    pulse_tick();

    // Tick collision: up pending, down event on the tick cycle is rejected
    press(4'b1000);
    expect_at(1, "col_setup_dir", SEL_DIR, 3);
    pulse_tick();
    expect_at(8, "col_up_pend", SEL_PEND, 1);
    press(4'b0001);
    down_n = 1'b0;
    step(7);
    expect_at(0, "col_prs", SEL_PRS, 2);
    tick = 1'b1;
    expect_at(1, "col_dir", SEL_DIR, 0);
    expect_at(1, "col_turn", SEL_TURN, 1);
    expect_at(1, "col_pend", SEL_PEND, 0);
    step(1);
    tick = 1'b0;
    expect_at(1, "col_pend_after", SEL_PEND, 0);
    expect_at(1, "col_dir_after", SEL_DIR, 0);
    step(1);
    down_n = 1'b1;
    step(8);

    // Reset mid-debounce with a request pending
    expect_at(8, "mid_up_pend", SEL_PEND, 1);
    press(4'b0001);
    left_n = 1'b0;
    step(4);
    reset = 1'b1;
    expect_all(1, "mid_reset", 3, 0, 0, 0);
    step(1);
    reset = 1'b0;
    expect_at(6, "mid_left_early", SEL_PRS, 0);
    expect_at(7, "mid_left_prs", SEL_PRS, 4);
    expect_at(8, "mid_left_pend", SEL_PEND, 0);
    expect_at(8, "mid_dir", SEL_DIR, 3);
    step(9);
    left_n = 1'b1;
    step(9);

    check_val("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
